// File: rtl/simon_says_engine.sv
// Simon Says game core: LFSR-generated symbol sequence, timed presentation and
// press checking. The sequence is never stored; it is regenerated from the seed.
module simon_says_engine #(
    parameter int unsigned BTN_W      = 2,
    parameter int unsigned CNT_W      = 6,
    parameter int unsigned MAX_LEN    = 63,
    parameter int unsigned SHOW_CYC   = 4,
    parameter int unsigned GAP_CYC    = 2,
    parameter int unsigned TIMEOUT    = 1000,
    parameter logic [15:0] FIXED_SEED = 16'h0000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [BTN_W-1:0] knapp_comb,
    input  logic             knapp_valid,
    output logic [BTN_W-1:0] show_sym,
    output logic             show_valid,
    output logic             correct_out,
    output logic             fail_out,
    output logic             win_out,
    output logic [CNT_W-1:0] count_out
);

    localparam int unsigned SlotCyc = GAP_CYC + SHOW_CYC;
    localparam int unsigned SlotW   = $clog2(SlotCyc + 1);
    localparam int unsigned TmrW    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    localparam logic [SlotW-1:0] GapEnd   = SlotW'(GAP_CYC);
    localparam logic [SlotW-1:0] SlotEnd  = SlotW'(SlotCyc - 1);
    localparam logic [TmrW-1:0]  TmrEnd   = TmrW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
    localparam logic [CNT_W-1:0] MaxLen   = CNT_W'(MAX_LEN);
    localparam logic [CNT_W-1:0] CntOne   = CNT_W'(1);
    localparam logic [15:0]      LfsrInit = 16'hACE1;
    localparam logic [15:0]      LfsrTaps = 16'hB400;

    typedef enum logic [2:0] {StIdle, StShow, StInput, StFail, StWin} state_e;

    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return (v >> 1) ^ (v[0] ? LfsrTaps : 16'h0000);
    endfunction

    state_e           state_q;
    logic [15:0]      free_q;
    logic [15:0]      seed_q;
    logic [15:0]      rep_q;
    logic [CNT_W-1:0] level_q;
    logic [CNT_W-1:0] idx_q;
    logic [SlotW-1:0] slot_q;
    logic [TmrW-1:0]  tmr_q;

    logic [15:0]      seed_now;
    logic [SlotW-1:0] slot_inc;
    logic             last_idx;

    assign seed_now = (FIXED_SEED != 16'h0000) ? FIXED_SEED : free_q;
    assign slot_inc = slot_q + SlotW'(1);
    assign last_idx = (idx_q == level_q - CntOne);

    always_ff @(posedge clk) begin
        if (rst) begin
            free_q <= LfsrInit;
        end else begin
            free_q <= lfsr_step(free_q);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            seed_q      <= 16'h0000;
            rep_q       <= 16'h0000;
            level_q     <= '0;
            idx_q       <= '0;
            slot_q      <= '0;
            tmr_q       <= '0;
            show_sym    <= '0;
            show_valid  <= 1'b0;
            correct_out <= 1'b0;
            fail_out    <= 1'b0;
            win_out     <= 1'b0;
            count_out   <= '0;
        end else begin
            correct_out <= 1'b0;
            show_valid  <= 1'b0;
            show_sym    <= '0;
            // start overrides everything, including a press in the same cycle
            if (start) begin
                state_q   <= StShow;
                seed_q    <= seed_now;
                rep_q     <= seed_now;
                level_q   <= CntOne;
                idx_q     <= '0;
                slot_q    <= '0;
                tmr_q     <= '0;
                fail_out  <= 1'b0;
                win_out   <= 1'b0;
                count_out <= '0;
            end else begin
                unique case (state_q)
                    StShow: begin
                        if (slot_q == SlotEnd) begin
                            slot_q <= '0;
                            if (last_idx) begin
                                state_q <= StInput;
                                idx_q   <= '0;
                                rep_q   <= seed_q;
                                tmr_q   <= '0;
                            end else begin
                                idx_q <= idx_q + CntOne;
                                rep_q <= lfsr_step(rep_q);
                            end
                        end else begin
                            slot_q <= slot_inc;
                            if (slot_inc >= GapEnd) begin
                                show_valid <= 1'b1;
                                show_sym   <= rep_q[BTN_W-1:0];
                            end
                        end
                    end
                    StInput: begin
                        if (knapp_valid) begin
                            tmr_q <= '0;
                            if (knapp_comb == rep_q[BTN_W-1:0]) begin
                                if (last_idx) begin
                                    correct_out <= 1'b1;
                                    count_out   <= level_q;
                                    if (level_q == MaxLen) begin
                                        state_q <= StWin;
                                        win_out <= 1'b1;
                                    end else begin
                                        state_q <= StShow;
                                        level_q <= level_q + CntOne;
                                        idx_q   <= '0;
                                        slot_q  <= '0;
                                        rep_q   <= seed_q;
                                    end
                                end else begin
                                    idx_q <= idx_q + CntOne;
                                    rep_q <= lfsr_step(rep_q);
                                end
                            end else begin
                                state_q  <= StFail;
                                fail_out <= 1'b1;
                            end
                        end else if (TIMEOUT != 0) begin
                            if (tmr_q == TmrEnd) begin
                                state_q  <= StFail;
                                fail_out <= 1'b1;
                            end else begin
                                tmr_q <= tmr_q + TmrW'(1);
                            end
                        end
                    end
                    default: begin
                        // IDLE, FAIL and WIN hold their flags until start
                    end
                endcase
            end
        end
    end

endmodule
